// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for NUM_DIGITS 7-segment digits
// sharing one 2-bit decoder. Each digit slot is an optional BLANK gap followed
// by a SHOW phase. New contents are captured into a shadow register and copied
// to the active register only in IDLE or at a frame boundary, so a frame never
// mixes old and new values.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   enable        scanning enable; low forces IDLE (dark)
//   load          load request, accepted when load && ready
//   load_data     digit i value at load_data[2i+1:2i]
//   ready         no load pending commit
//   dec_in        value presented to the shared decoder
//   digit_en      one-hot digit enable, zero when dark
//   frame_done    one-cycle pulse after the last digit's SHOW phase
module display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [2*NUM_DIGITS-1:0] load_data,
  output logic                    ready,
  output logic [1:0]              dec_in,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAXC    = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int BL_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int SH_LAST = SHOW_CYCLES - 1;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  // Phase that starts every digit slot: skip BLANK entirely when it has no length.
  localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][1:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][1:0]     active_q, active_d;
  logic                           pending_q, pending_d;
  logic                           fd_q, fd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    fd_d      = 1'b0;

    // Capture is blocked while pending, so it can never collide with a commit below.
    if (load && !pending_q) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
        if (enable) state_d = SLOT_START;
      end
      S_BLANK: begin
        if (!enable) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(BL_LAST)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (!enable) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(SH_LAST)) begin
          state_d = SLOT_START;
          cnt_d   = '0;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            // Frame boundary: swap in pending contents before digit 0 is shown.
            idx_d = '0;
            fd_d  = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so they move solely on clock edges or reset.
  assign ready      = !pending_q;
  assign frame_done = fd_q;
  assign dec_in     = (state_q == S_IDLE) ? 2'b00 : active_q[idx_q];
  assign digit_en   = (state_q == S_SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing controller for a bank of 7-segment digits that share one 2-bit-to-7-segment decoder. Holds one 2-bit value per digit and walks through the digits, presenting each value to the shared decoder's input and driving a one-hot digit enable. Each digit slot can start with a programmable blanking gap to suppress ghosting. New display contents are loaded through a ready/valid-style handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (>=2)
- SHOW_CYCLES, 1000, cycles each digit is lit per slot (>=1)
- BLANK_CYCLES, 50, all-dark cycles before each digit's SHOW phase (>=0; 0 = no blanking)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scanning enabled; low forces dark/IDLE
- load  in  1  load request; accepted when load && ready
- load_data  in  2*NUM_DIGITS  digit values; digit i = load_data[2i+1:2i]
- ready  out  1  high when no load is pending commit
- dec_in  out  2  value driven to the shared decoder input
- digit_en  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark
- frame_done  out  1  one-cycle pulse at the end of each completed frame

## Operation
- Registers:
  - shadow: 2*NUM_DIGITS bits, written on an accepted load.
  - active: 2*NUM_DIGITS bits, the values being displayed.
  - pending: 1 bit; ready = !pending.
  - idx: current digit, 0..NUM_DIGITS-1.
  - cnt: phase cycle counter, sized for max(SHOW_CYCLES, BLANK_CYCLES).
- States:
  - IDLE: enable low.
  - BLANK: dark gap before digit idx.
  - SHOW: digit idx lit.
- IDLE:
  - digit_en = 0, dec_in = 0, idx = 0, cnt = 0.
  - If pending, commit (active <= shadow, pending <= 0) on the next edge.
  - On enable high, go to BLANK with idx = 0. If BLANK_CYCLES = 0, go straight to SHOW.
- BLANK:
  - digit_en = 0; dec_in = value of digit idx in active.
  - Lasts exactly BLANK_CYCLES cycles, then goes to SHOW.
- SHOW:
  - digit_en = one-hot(idx); dec_in = value of digit idx in active.
  - Lasts exactly SHOW_CYCLES cycles.
  - On exit, idx advances and the block enters BLANK (or SHOW if BLANK_CYCLES = 0) for the next digit.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary (exit of SHOW for idx = NUM_DIGITS-1):
  - frame_done pulses.
  - If pending, commit on the same edge, so digit 0 of the next frame uses the new values.
- Load handshake:
  - On load && ready: shadow <= load_data, pending <= 1.
  - While ready is low, load is ignored; shadow is not overwritten.
  - Load and commit can never occur on the same edge, because ready is low whenever pending is set.
- enable falling in any state: next edge goes to IDLE and digit_en clears. A pending load is kept and commits in IDLE.
- enable rising: scanning always restarts at digit 0 with a fresh BLANK.

## Timing
- All outputs are registered and change only on clk rising edges, except on reset.
- Reset (asynchronous, takes effect immediately):
  - State IDLE, idx = 0, cnt = 0, shadow = 0, active = 0, pending = 0.
  - Outputs: ready = 1, dec_in = 00, digit_en = 0, frame_done = 0.
- Reset asserted mid-frame clears all outputs with no clock edge required.
- dec_in takes the next digit's value on the same edge that enters that digit's BLANK (or SHOW when BLANK_CYCLES = 0).
  - With BLANK_CYCLES >= 1, dec_in is therefore stable at least one cycle before digit_en lights.
- digit_en is never multi-hot. With BLANK_CYCLES >= 1, it is all-zero for exactly BLANK_CYCLES cycles between consecutive digits.
- Timing quantities:
  - Frame length = NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles.
  - Enable-to-first-light latency = 1 + BLANK_CYCLES cycles.
  - Load-to-display latency in IDLE: ready is low for exactly 1 cycle.
  - Load-to-display latency while scanning: ready stays low until the frame boundary edge.

## Test plan
All scenarios use NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2 unless noted.
- Reset check: drive rst high mid-SHOW between clock edges -> digit_en=0000, dec_in=00, ready=1 and frame_done=0 immediately; IDLE after release.
- Basic scan: in IDLE, load 8'b11_10_01_00 -> ready low 1 cycle. Then enable=1 -> sequence per digit:
  - Digit 0: BLANK 2 cycles (dec_in=00, en=0000), then SHOW 4 cycles (en=0001).
  - Digits 1, 2, 3: dec_in=01/10/11 with en=0010/0100/1000.
  - frame_done pulses once every 24 cycles.
- Mid-frame load: during digit 1 SHOW, load 8'h00 -> digits 2 and 3 still show 10 and 11, and ready stays low until the frame boundary. A second load 8'hFF while ready is low is ignored. The next frame shows all 00.
- Enable drop: deassert enable mid-SHOW of digit 2 -> next edge digit_en=0000 and IDLE. Reassert -> restarts at digit 0 BLANK.
- No-blank config (BLANK_CYCLES=0): digit_en goes 0001->0010->0100->1000 every 4 cycles with no all-zero gap; frame is 16 cycles.
- Load while disabled with pending: load in IDLE -> commit on next edge. Enable on that same edge -> first digit uses the new value.
